// File: rtl/lhrom_map_wbuf.sv
`default_nettype none
// ============================================================================
// lhrom_map_wbuf : LoROM/HiROM/ExHiROM/96Mbit cartridge mapper with REQ/ACK
//                  ROM and BSRAM ports and a posted BSRAM write buffer.
//                  Optional: `LHROM_WBUF_FWD_EN forwards buffered writes to reads.
// Revision: 1.0
// ============================================================================
module lhrom_map_wbuf #(
    parameter int ROM_AW     = 24,
    parameter int RAM_AW     = 20,
    parameter int WBUF_DEPTH = 4
) (
    input  logic              WCLK,
    input  logic              RST_N,
    input  logic [23:0]       CA,
    input  logic [7:0]        DI,
    output logic [7:0]        DO,
    input  logic              CPURD_N,
    input  logic              CPUWR_N,
    input  logic              ROMSEL_N,
    input  logic              SYSCLKF_CE,
    input  logic              SYSCLKR_CE,
    input  logic [1:0]        MAP_CTRL,
    input  logic [ROM_AW-1:0] ROM_MASK,
    input  logic [RAM_AW-1:0] BSRAM_MASK,
    output logic              ROM_REQ,
    output logic [ROM_AW-1:0] ROM_ADDR,
    input  logic              ROM_ACK,
    input  logic [7:0]        ROM_Q,
    output logic              RAM_REQ,
    output logic              RAM_WE,
    output logic [RAM_AW-1:0] RAM_ADDR,
    output logic [7:0]        RAM_D,
    input  logic              RAM_ACK,
    input  logic [7:0]        RAM_Q,
    output logic              WBUF_FULL,
    output logic              WBUF_EMPTY,
    output logic              WBUF_DROP
);
    localparam int PW = $clog2(WBUF_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = RAM_AW + 8;

    localparam logic [1:0] C_SEL_NONE = 2'd0;
    localparam logic [1:0] C_SEL_ROM  = 2'd1;
    localparam logic [1:0] C_SEL_RAM  = 2'd2;

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_ROMRD = 2'd1;
    localparam logic [1:0] C_ST_RAMRD = 2'd2;
    localparam logic [1:0] C_ST_DRAIN = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              pend_q, pend_d;
    logic [1:0]        sel_q;
    logic [ROM_AW-1:0] rom_addr_q;
    logic [RAM_AW-1:0] ram_rd_addr_q;
    logic              rom_req_q, rom_req_d;
    logic              ram_req_q, ram_req_d;
    logic              ram_we_q, ram_we_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_d_q, ram_d_d;
    logic [7:0]        rdata_q, rdata_d;
    logic [7:0]        openbus_q;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              drop_q;
    logic [EW-1:0]     wbuf_mem_q [WBUF_DEPTH];

    logic [7:0]        w_bank;
    logic [23:0]       w_cart;
    logic [19:0]       w_ram_raw;
    logic              w_ram_win;
    logic              w_lo_win;
    logic              w_hi_win;
    logic              w_ram_hit;
    logic [1:0]        w_sel;
    logic [ROM_AW-1:0] w_rom_addr;
    logic [RAM_AW-1:0] w_ram_addr;
    logic              w_new_rd;
    logic [1:0]        w_rd_sel;
    logic [RAM_AW-1:0] w_rd_addr;
    logic              w_fwd_hit;
    logic [7:0]        w_fwd_data;
    logic [EW-1:0]     w_head;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_do_push;
    logic              w_pop;

    assign w_bank   = CA[23:16];
    assign w_lo_win = ((w_bank >= 8'h70 && w_bank <= 8'h7D) || w_bank >= 8'hF0)
                      && !CA[15] && !ROMSEL_N;
    assign w_hi_win = (w_bank[6:5] == 2'b01) && (CA[15:13] == 3'b011);

    always_comb begin
        w_cart    = 24'h0;
        w_ram_raw = 20'h0;
        w_ram_win = 1'b0;
        case (MAP_CTRL)
            2'd0: begin
                w_cart    = {1'b0, ~CA[23], CA[22:16], CA[14:0]};
                w_ram_raw = {CA[20:16], CA[14:0]};
                w_ram_win = w_lo_win;
            end
            2'd1: begin
                w_cart    = {2'b00, CA[21:0]};
                w_ram_raw = {2'b00, CA[20:16], CA[12:0]};
                w_ram_win = w_hi_win;
            end
            2'd2: begin
                w_cart    = {1'b0, ~CA[23], CA[21:0]};
                w_ram_raw = {2'b00, CA[20:16], CA[12:0]};
                w_ram_win = w_hi_win;
            end
            default: begin
                w_cart    = CA[15] ? {1'b0, CA[23:16], CA[14:0]}
                                   : {2'b10, CA[23], CA[21:16], CA[14:0]};
                w_ram_raw = {2'b00, CA[20:16], CA[12:0]};
                w_ram_win = w_hi_win;
            end
        endcase
    end

    assign w_ram_hit  = w_ram_win && BSRAM_MASK[10];
    assign w_sel      = w_ram_hit ? C_SEL_RAM : (!ROMSEL_N ? C_SEL_ROM : C_SEL_NONE);
    assign w_rom_addr = ROM_AW'(w_cart) & ROM_MASK;
    assign w_ram_addr = RAM_AW'(w_ram_raw) & BSRAM_MASK;

    // A fresh bus cycle overrides any pending one: address registers always hold the latest.
    assign w_new_rd  = SYSCLKF_CE && !CPURD_N && (w_sel != C_SEL_NONE);
    assign w_rd_sel  = w_new_rd ? w_sel : sel_q;
    assign w_rd_addr = w_new_rd ? w_ram_addr : ram_rd_addr_q;

    assign w_head    = wbuf_mem_q[rd_ptr_q];
    assign w_empty   = (count_q == '0);
    assign w_full    = (count_q == CW'(WBUF_DEPTH));
    assign w_push    = SYSCLKR_CE && !CPUWR_N && (sel_q == C_SEL_RAM);
    assign w_do_push = w_push && (!w_full || w_pop);

`ifdef LHROM_WBUF_FWD_EN
    // Walk oldest to newest so the newest matching entry wins.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = 8'h00;
        for (int k = 0; k < WBUF_DEPTH; k++) begin
            if ((CW'(k) < count_q) &&
                (wbuf_mem_q[rd_ptr_q + PW'(k)][EW-1:8] == w_rd_addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = wbuf_mem_q[rd_ptr_q + PW'(k)][7:0];
            end
        end
    end
`else
    assign w_fwd_hit  = 1'b0;
    assign w_fwd_data = 8'h00;
`endif

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        rom_req_d  = rom_req_q;
        ram_req_d  = ram_req_q;
        ram_we_d   = ram_we_q;
        ram_addr_d = ram_addr_q;
        ram_d_d    = ram_d_q;
        rdata_d    = rdata_q;
        w_pop      = 1'b0;
        case (state_q)
            C_ST_IDLE: begin
                if (w_new_rd || pend_q) begin
                    pend_d = 1'b0;
                    if (w_rd_sel == C_SEL_ROM) begin
                        state_d   = C_ST_ROMRD;
                        rom_req_d = 1'b1;
                    end else if (w_fwd_hit) begin
                        rdata_d = w_fwd_data;
                    end else begin
                        state_d    = C_ST_RAMRD;
                        ram_req_d  = 1'b1;
                        ram_we_d   = 1'b0;
                        ram_addr_d = w_rd_addr;
                    end
                end else if (!w_empty) begin
                    state_d    = C_ST_DRAIN;
                    ram_req_d  = 1'b1;
                    ram_we_d   = 1'b1;
                    ram_addr_d = w_head[EW-1:8];
                    ram_d_d    = w_head[7:0];
                end
            end
            C_ST_ROMRD: begin
                if (SYSCLKF_CE) pend_d = w_new_rd;
                if (ROM_ACK) begin
                    rom_req_d = 1'b0;
                    rdata_d   = ROM_Q;
                    state_d   = C_ST_IDLE;
                end
            end
            C_ST_RAMRD: begin
                if (SYSCLKF_CE) pend_d = w_new_rd;
                if (RAM_ACK) begin
                    ram_req_d = 1'b0;
                    rdata_d   = RAM_Q;
                    state_d   = C_ST_IDLE;
                end
            end
            default: begin
                if (SYSCLKF_CE) pend_d = w_new_rd;
                if (RAM_ACK) begin
                    ram_req_d = 1'b0;
                    ram_we_d  = 1'b0;
                    w_pop     = 1'b1;
                    state_d   = C_ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge WCLK) begin
        if (!RST_N) begin
            state_q       <= C_ST_IDLE;
            pend_q        <= 1'b0;
            sel_q         <= C_SEL_NONE;
            rom_addr_q    <= '0;
            ram_rd_addr_q <= '0;
            rom_req_q     <= 1'b0;
            ram_req_q     <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_d_q       <= 8'h00;
            rdata_q       <= 8'hFF;
            openbus_q     <= 8'hFF;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            drop_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            rom_req_q  <= rom_req_d;
            ram_req_q  <= ram_req_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_d_q    <= ram_d_d;
            rdata_q    <= rdata_d;
            drop_q     <= w_push && w_full && !w_pop;
            if (SYSCLKF_CE) begin
                sel_q         <= w_sel;
                rom_addr_q    <= w_rom_addr;
                ram_rd_addr_q <= w_ram_addr;
            end
            if (SYSCLKR_CE) openbus_q <= DI;
            if (w_do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (w_pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
            if (w_do_push && !w_pop)      count_q <= count_q + CW'(1);
            else if (!w_do_push && w_pop) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge WCLK) begin
        if (w_do_push) wbuf_mem_q[wr_ptr_q] <= {ram_rd_addr_q, DI};
    end

    assign DO         = (sel_q != C_SEL_NONE) ? rdata_q : openbus_q;
    assign ROM_REQ    = rom_req_q;
    assign ROM_ADDR   = rom_addr_q;
    assign RAM_REQ    = ram_req_q;
    assign RAM_WE     = ram_we_q;
    assign RAM_ADDR   = ram_addr_q;
    assign RAM_D      = ram_d_q;
    assign WBUF_FULL  = w_full;
    assign WBUF_EMPTY = w_empty;
    assign WBUF_DROP  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_lhrom_map_wbuf.sv
`default_nettype none
// ============================================================================
// tb_lhrom_map_wbuf : directed bench for lhrom_map_wbuf (decode table plus
//                     write-buffer, pending-read and reset sequences).
// Revision: 1.0
// ============================================================================
module tb_lhrom_map_wbuf;
    localparam logic [1:0] SNONE = 2'd0;
    localparam logic [1:0] SROM  = 2'd1;
    localparam logic [1:0] SRAM  = 2'd2;

    logic        WCLK = 1'b0;
    logic        RST_N;
    logic [23:0] CA;
    logic [7:0]  DI;
    logic [7:0]  DO;
    logic        CPURD_N, CPUWR_N, ROMSEL_N, SYSCLKF_CE, SYSCLKR_CE;
    logic [1:0]  MAP_CTRL;
    logic [23:0] ROM_MASK;
    logic [19:0] BSRAM_MASK;
    logic        ROM_REQ, ROM_ACK;
    logic [23:0] ROM_ADDR;
    logic [7:0]  ROM_Q;
    logic        RAM_REQ, RAM_WE, RAM_ACK;
    logic [19:0] RAM_ADDR;
    logic [7:0]  RAM_D, RAM_Q;
    logic        WBUF_FULL, WBUF_EMPTY, WBUF_DROP;

    lhrom_map_wbuf #(.ROM_AW(24), .RAM_AW(20), .WBUF_DEPTH(4)) dut (
        .WCLK(WCLK), .RST_N(RST_N), .CA(CA), .DI(DI), .DO(DO),
        .CPURD_N(CPURD_N), .CPUWR_N(CPUWR_N), .ROMSEL_N(ROMSEL_N),
        .SYSCLKF_CE(SYSCLKF_CE), .SYSCLKR_CE(SYSCLKR_CE), .MAP_CTRL(MAP_CTRL),
        .ROM_MASK(ROM_MASK), .BSRAM_MASK(BSRAM_MASK),
        .ROM_REQ(ROM_REQ), .ROM_ADDR(ROM_ADDR), .ROM_ACK(ROM_ACK), .ROM_Q(ROM_Q),
        .RAM_REQ(RAM_REQ), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR), .RAM_D(RAM_D),
        .RAM_ACK(RAM_ACK), .RAM_Q(RAM_Q),
        .WBUF_FULL(WBUF_FULL), .WBUF_EMPTY(WBUF_EMPTY), .WBUF_DROP(WBUF_DROP)
    );

    always #5 WCLK = ~WCLK;

    typedef struct {
        logic [1:0]  map;
        logic [23:0] ca;
        logic        rs;
        logic [23:0] rmask;
        logic [19:0] bmask;
        logic [1:0]  sel;
        logic [23:0] rom_a;
        logic [19:0] ram_a;
        logic [7:0]  q;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] ob_exp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic bus_read(input logic [23:0] a, input logic rs);
        CA = a; ROMSEL_N = rs; CPURD_N = 1'b0; SYSCLKF_CE = 1'b1;
        @(negedge WCLK);
        SYSCLKF_CE = 1'b0; CPURD_N = 1'b1;
    endtask

    task automatic bus_write(input logic [23:0] a, input logic rs, input logic [7:0] d);
        CA = a; ROMSEL_N = rs; CPUWR_N = 1'b0; SYSCLKF_CE = 1'b1;
        @(negedge WCLK);
        SYSCLKF_CE = 1'b0; SYSCLKR_CE = 1'b1; DI = d;
        @(negedge WCLK);
        SYSCLKR_CE = 1'b0; CPUWR_N = 1'b1;
    endtask

    task automatic drain_one(input string nm, input logic [19:0] ea, input logic [7:0] ed);
        int k;
        k = 0;
        while (!(RAM_REQ && RAM_WE) && k < 8) begin
            @(negedge WCLK);
            k++;
        end
        chk({nm, " wr_req"}, {31'h0, RAM_REQ & RAM_WE}, 32'h1);
        chk({nm, " wr_addr"}, {12'h0, RAM_ADDR}, {12'h0, ea});
        chk({nm, " wr_data"}, {24'h0, RAM_D}, {24'h0, ed});
        RAM_ACK = 1'b1;
        @(negedge WCLK);
        RAM_ACK = 1'b0;
        chk({nm, " req_fall"}, {31'h0, RAM_REQ}, 32'h0);
    endtask

    initial begin
        vecs[0]  = '{2'd1, 24'hC08123, 1'b0, 24'h3FFFFF, 20'h1FFFF, SROM,  24'h008123, 20'h0,     8'h5A};
        vecs[1]  = '{2'd0, 24'h708004, 1'b0, 24'h3FFFFF, 20'h1FFFF, SROM,  24'h380004, 20'h0,     8'h61};
        vecs[2]  = '{2'd0, 24'h700004, 1'b0, 24'h3FFFFF, 20'h1FFFF, SRAM,  24'h0,      20'h00004, 8'h62};
        vecs[3]  = '{2'd0, 24'h700004, 1'b0, 24'h3FFFFF, 20'h003FF, SROM,  24'h380004, 20'h0,     8'h63};
        vecs[4]  = '{2'd0, 24'hFD7ABC, 1'b0, 24'h3FFFFF, 20'hFFFFF, SRAM,  24'h0,      20'hEFABC, 8'h64};
        vecs[5]  = '{2'd0, 24'h7E1234, 1'b1, 24'h3FFFFF, 20'hFFFFF, SNONE, 24'h0,      20'h0,     8'h00};
        vecs[6]  = '{2'd0, 24'h700000, 1'b1, 24'h3FFFFF, 20'hFFFFF, SNONE, 24'h0,      20'h0,     8'h00};
        vecs[7]  = '{2'd1, 24'h206010, 1'b1, 24'h3FFFFF, 20'h1FFFF, SRAM,  24'h0,      20'h00010, 8'h67};
        vecs[8]  = '{2'd1, 24'hBF7FFF, 1'b1, 24'h3FFFFF, 20'h0FFFF, SRAM,  24'h0,      20'h0FFFF, 8'h68};
        vecs[9]  = '{2'd1, 24'h205FFF, 1'b1, 24'h3FFFFF, 20'h1FFFF, SNONE, 24'h0,      20'h0,     8'h00};
        vecs[10] = '{2'd2, 24'h400000, 1'b0, 24'hFFFFFF, 20'h1FFFF, SROM,  24'h400000, 20'h0,     8'h6A};
        vecs[11] = '{2'd2, 24'hC12345, 1'b0, 24'hFFFFFF, 20'h1FFFF, SROM,  24'h012345, 20'h0,     8'h6B};
        vecs[12] = '{2'd3, 24'hC01234, 1'b0, 24'hFFFFFF, 20'h1FFFF, SROM,  24'hA01234, 20'h0,     8'h6C};
        vecs[13] = '{2'd3, 24'h5A9234, 1'b0, 24'hFFFFFF, 20'h1FFFF, SROM,  24'h2D1234, 20'h0,     8'h6D};
        vecs[14] = '{2'd3, 24'hA07000, 1'b1, 24'hFFFFFF, 20'h1FFFF, SRAM,  24'h0,      20'h01000, 8'h6E};

        RST_N = 1'b0; CA = 24'h0; DI = 8'h00; CPURD_N = 1'b1; CPUWR_N = 1'b1;
        ROMSEL_N = 1'b1; SYSCLKF_CE = 1'b0; SYSCLKR_CE = 1'b0; MAP_CTRL = 2'd1;
        ROM_MASK = 24'h3FFFFF; BSRAM_MASK = 20'h1FFFF;
        ROM_ACK = 1'b0; ROM_Q = 8'h00; RAM_ACK = 1'b0; RAM_Q = 8'h00;
        ob_exp = 8'hFF;
        repeat (3) @(negedge WCLK);

        // reset state
        chk("rst ROM_REQ", {31'h0, ROM_REQ}, 32'h0);
        chk("rst RAM_REQ", {31'h0, RAM_REQ}, 32'h0);
        chk("rst RAM_WE", {31'h0, RAM_WE}, 32'h0);
        chk("rst ROM_ADDR", {8'h0, ROM_ADDR}, 32'h0);
        chk("rst RAM_ADDR", {12'h0, RAM_ADDR}, 32'h0);
        chk("rst RAM_D", {24'h0, RAM_D}, 32'h0);
        chk("rst DO", {24'h0, DO}, 32'hFF);
        chk("rst flags", {29'h0, WBUF_EMPTY, WBUF_FULL, WBUF_DROP}, 32'h4);
        RST_N = 1'b1;
        @(negedge WCLK);

        // decode table
        for (int i = 0; i < NV; i++) begin
            MAP_CTRL = vecs[i].map; ROM_MASK = vecs[i].rmask; BSRAM_MASK = vecs[i].bmask;
            bus_read(vecs[i].ca, vecs[i].rs);
            chk($sformatf("v%0d ROM_REQ", i), {31'h0, ROM_REQ}, {31'h0, vecs[i].sel == SROM});
            chk($sformatf("v%0d RAM_REQ", i), {31'h0, RAM_REQ}, {31'h0, vecs[i].sel == SRAM});
            if (vecs[i].sel == SROM)
                chk($sformatf("v%0d ROM_ADDR", i), {8'h0, ROM_ADDR}, {8'h0, vecs[i].rom_a});
            if (vecs[i].sel == SRAM) begin
                chk($sformatf("v%0d RAM_ADDR", i), {12'h0, RAM_ADDR}, {12'h0, vecs[i].ram_a});
                chk($sformatf("v%0d RAM_WE", i), {31'h0, RAM_WE}, 32'h0);
            end
            if (vecs[i].sel != SNONE) begin
                ROM_ACK = (vecs[i].sel == SROM); RAM_ACK = (vecs[i].sel == SRAM);
                ROM_Q = vecs[i].q; RAM_Q = vecs[i].q;
                @(negedge WCLK);
                ROM_ACK = 1'b0; RAM_ACK = 1'b0;
                chk($sformatf("v%0d DO", i), {24'h0, DO}, {24'h0, vecs[i].q});
                chk($sformatf("v%0d req_fall", i), {30'h0, ROM_REQ, RAM_REQ}, 32'h0);
            end else begin
                chk($sformatf("v%0d DO openbus", i), {24'h0, DO}, {24'h0, ob_exp});
            end
            @(negedge WCLK);
        end

        // HiROM read with ROM_ACK after three cycles
        MAP_CTRL = 2'd1; ROM_MASK = 24'h3FFFFF; BSRAM_MASK = 20'h1FFFF;
        bus_read(24'hC08123, 1'b0);
        chk("slow ROM_ADDR", {8'h0, ROM_ADDR}, 32'h008123);
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("slow hold %0d", c), {31'h0, ROM_REQ}, 32'h1);
            @(negedge WCLK);
        end
        ROM_ACK = 1'b1; ROM_Q = 8'h5A;
        @(negedge WCLK);
        ROM_ACK = 1'b0; ROM_Q = 8'h00;
        chk("slow DO", {24'h0, DO}, 32'h5A);
        chk("slow req_fall", {31'h0, ROM_REQ}, 32'h0);
        @(negedge WCLK);
        chk("slow no_rearm", {31'h0, ROM_REQ}, 32'h0);

        // five writes into a four-deep buffer with RAM_ACK held low
        for (int i = 0; i < 5; i++) begin
            bus_write(24'h206000 + 24'(i), 1'b1, 8'h11 + 8'(i));
            chk($sformatf("ovf drop %0d", i), {31'h0, WBUF_DROP}, {31'h0, i == 4});
            chk($sformatf("ovf full %0d", i), {31'h0, WBUF_FULL}, {31'h0, i >= 3});
        end
        ob_exp = 8'h15;
        @(negedge WCLK);
        chk("ovf drop_pulse", {31'h0, WBUF_DROP}, 32'h0);
        for (int i = 0; i < 4; i++)
            drain_one($sformatf("ovf d%0d", i), 20'(i), 8'h11 + 8'(i));
        chk("ovf empty", {31'h0, WBUF_EMPTY}, 32'h1);
        repeat (2) @(negedge WCLK);
        chk("ovf idle", {31'h0, RAM_REQ}, 32'h0);

        // read-after-write to a buffered address before its drain starts
        bus_write(24'h206010, 1'b1, 8'h33);
        bus_read(24'h206010, 1'b1);
`ifdef LHROM_WBUF_FWD_EN
        chk("fwd DO", {24'h0, DO}, 32'h33);
        chk("fwd no_req", {31'h0, RAM_REQ}, 32'h0);
`else
        chk("raw rd_req", {30'h0, RAM_REQ, RAM_WE}, 32'h2);
        chk("raw rd_addr", {12'h0, RAM_ADDR}, 32'h10);
        RAM_ACK = 1'b1; RAM_Q = 8'h99;
        @(negedge WCLK);
        RAM_ACK = 1'b0;
        chk("raw DO", {24'h0, DO}, 32'h99);
`endif
        drain_one("raw d", 20'h10, 8'h33);
        chk("raw empty", {31'h0, WBUF_EMPTY}, 32'h1);

        // read arriving during a drain is held pending
        bus_write(24'h206020, 1'b1, 8'h44);
        @(negedge WCLK);
        chk("pend drain_on", {30'h0, RAM_REQ, RAM_WE}, 32'h3);
        bus_read(24'h206030, 1'b1);
        chk("pend drain_kept", {12'h0, RAM_ADDR}, 32'h20);
        drain_one("pend d", 20'h20, 8'h44);
        @(negedge WCLK);
        chk("pend rd_req", {30'h0, RAM_REQ, RAM_WE}, 32'h2);
        chk("pend rd_addr", {12'h0, RAM_ADDR}, 32'h30);
        RAM_ACK = 1'b1; RAM_Q = 8'h77;
        @(negedge WCLK);
        RAM_ACK = 1'b0;
        chk("pend DO", {24'h0, DO}, 32'h77);
        chk("pend req_fall", {31'h0, RAM_REQ}, 32'h0);

        // push and pop in the same cycle while full
        for (int i = 0; i < 4; i++) bus_write(24'h206000 + 24'(i), 1'b1, 8'hA0 + 8'(i));
        chk("pp full", {31'h0, WBUF_FULL}, 32'h1);
        CA = 24'h206004; ROMSEL_N = 1'b1; CPUWR_N = 1'b0; SYSCLKF_CE = 1'b1;
        @(negedge WCLK);
        SYSCLKF_CE = 1'b0; SYSCLKR_CE = 1'b1; DI = 8'hA4; RAM_ACK = 1'b1;
        @(negedge WCLK);
        SYSCLKR_CE = 1'b0; CPUWR_N = 1'b1; RAM_ACK = 1'b0;
        chk("pp no_drop", {31'h0, WBUF_DROP}, 32'h0);
        chk("pp still_full", {31'h0, WBUF_FULL}, 32'h1);
        for (int i = 1; i < 5; i++)
            drain_one($sformatf("pp d%0d", i), 20'(i), 8'hA0 + 8'(i));
        chk("pp empty", {31'h0, WBUF_EMPTY}, 32'h1);

        // reset while a ROM request is outstanding and the buffer is non-empty
        bus_write(24'h206040, 1'b1, 8'h55);
        bus_read(24'hC08123, 1'b0);
        chk("mrst pre_req", {31'h0, ROM_REQ}, 32'h1);
        chk("mrst pre_empty", {31'h0, WBUF_EMPTY}, 32'h0);
        RST_N = 1'b0;
        @(negedge WCLK);
        chk("mrst ROM_REQ", {31'h0, ROM_REQ}, 32'h0);
        chk("mrst empty", {31'h0, WBUF_EMPTY}, 32'h1);
        chk("mrst DO", {24'h0, DO}, 32'hFF);
        RST_N = 1'b1;
        repeat (2) @(negedge WCLK);
        chk("mrst no_drain", {30'h0, RAM_REQ, ROM_REQ}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
